// File: rtl/sprite_oam_dma_pkg.sv
`default_nettype none
// ============================================================================
// sprite_oam_dma_pkg : shared FSM encoding and sprite constants for sprite_oam_dma
// Rev 1.0
// ============================================================================
package sprite_oam_dma_pkg;

   localparam int SPRITE_NUM_MAX = 64;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_VB = 3'd1,
      REQ     = 3'd2,
      WRITE   = 3'd3,
      FIN     = 3'd4
   } dma_state_t;

`ifdef SPRITE_OAM_DMA_CLEAR_EN
   // Y coordinate parked below the visible area so the sprite never draws.
   localparam logic [31:0] SPRITE_HIDE_WORD = 32'h0000_00F0;
`endif

endpackage
`default_nettype wire

// File: rtl/sprite_oam_dma.sv
`default_nettype none
// ============================================================================
// sprite_oam_dma : copies sprite entries from a source bus into sprite RAM during vblank.
// Optional clear mode (write hide word to every entry) under SPRITE_OAM_DMA_CLEAR_EN.
// Rev 1.0
// ============================================================================
module sprite_oam_dma
   import sprite_oam_dma_pkg::*;
#(
   parameter int SPRITE_NUM = SPRITE_NUM_MAX,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          start,
   input  logic [ADDR_W-1:0]             srcBase,
   input  logic [$clog2(SPRITE_NUM):0]   len,
`ifdef SPRITE_OAM_DMA_CLEAR_EN
   input  logic                          clearMode,
`endif
   input  logic                          vblank,
   output logic                          srcReq,
   output logic [ADDR_W-1:0]             srcAddr,
   input  logic                          srcAck,
   input  logic [DATA_W-1:0]             srcData,
   output logic                          oamWe,
   output logic [$clog2(SPRITE_NUM)-1:0] oamAddr,
   output logic [DATA_W-1:0]             oamWdata,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int IW = $clog2(SPRITE_NUM);
   localparam int LW = IW + 1;

   dma_state_t        state, state_nxt;
   logic [IW-1:0]     idx;
   logic [LW-1:0]     eff_len;
   logic [ADDR_W-1:0] base;
   logic [DATA_W-1:0] data_q;
   logic [LW-1:0]     len_eff;
   logic              last;
   logic              clr;

   // Zero and anything larger than the RAM both mean "the whole RAM".
   assign len_eff = ((len == '0) || (len > LW'(SPRITE_NUM))) ? LW'(SPRITE_NUM) : len;
   assign last    = ((LW'(idx) + LW'(1)) == eff_len);

`ifdef SPRITE_OAM_DMA_CLEAR_EN
   logic clr_q;
   assign clr = clr_q;
`else
   assign clr = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         idx     <= '0;
         eff_len <= '0;
         base    <= '0;
         data_q  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            base    <= srcBase;
            eff_len <= len_eff;
            idx     <= '0;
         end
         if (state == REQ && srcAck) data_q <= srcData;
         if (state == WRITE)         idx    <= idx + 1'b1;
      end
   end

`ifdef SPRITE_OAM_DMA_CLEAR_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                      clr_q <= 1'b0;
      else if (state == IDLE && start) clr_q <= clearMode;
   end
`endif

   // Every non-final entry passes through WAIT_VB, which is also where a
   // vblank drop parks the transfer with idx intact.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = WAIT_VB;
         WAIT_VB: if (vblank) state_nxt = clr ? WRITE : REQ;
         REQ:     if (srcAck) state_nxt = WRITE;
         WRITE:   state_nxt = last ? FIN : WAIT_VB;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      srcReq   = 1'b0;
      srcAddr  = '0;
      oamWe    = 1'b0;
      oamAddr  = '0;
      oamWdata = '0;
      if (state == REQ) begin
         srcReq  = 1'b1;
         srcAddr = base + (ADDR_W'(idx) << 2);
      end
      if (state == WRITE) begin
         oamWe   = 1'b1;
         oamAddr = idx;
`ifdef SPRITE_OAM_DMA_CLEAR_EN
         oamWdata = clr ? DATA_W'(SPRITE_HIDE_WORD) : data_q;
`else
         oamWdata = data_q;
`endif
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == FIN);
   assign err  = start && (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sprite_oam_dma.sv
`default_nettype none
// ============================================================================
// tb_sprite_oam_dma : table-driven cycle check of a basic copy plus directed corner sequences.
// Rev 1.0
// ============================================================================
module tb_sprite_oam_dma;
   import sprite_oam_dma_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic [15:0] srcBase = '0;
   logic [6:0]  len = '0;
   logic        vblank = 1'b0;
   logic        srcAck = 1'b0;
   logic [31:0] srcData;
   logic        srcReq, oamWe, busy, done, err;
   logic [15:0] srcAddr;
   logic [5:0]  oamAddr;
   logic [31:0] oamWdata;
   logic        auto_data = 1'b0;
   logic [31:0] tab_data = '0;
`ifdef SPRITE_OAM_DMA_CLEAR_EN
   logic        clearMode = 1'b0;
`endif

   assign srcData = auto_data ? {16'hD00D, srcAddr} : tab_data;

   sprite_oam_dma #(.SPRITE_NUM(64), .DATA_W(32), .ADDR_W(16)) dut (
      .clk(clk), .rstn(rstn), .start(start), .srcBase(srcBase), .len(len),
`ifdef SPRITE_OAM_DMA_CLEAR_EN
      .clearMode(clearMode),
`endif
      .vblank(vblank), .srcReq(srcReq), .srcAddr(srcAddr), .srcAck(srcAck),
      .srcData(srcData), .oamWe(oamWe), .oamAddr(oamAddr), .oamWdata(oamWdata),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor logs writes, accepted requests and pulses.
   logic [5:0]  wr_idx_q[$];
   logic [31:0] wr_dat_q[$];
   logic [15:0] req_q[$];
   int done_cnt = 0, err_cnt = 0, req_seen = 0;

   always @(negedge clk) begin
      if (rstn) begin
         if (oamWe) begin
            wr_idx_q.push_back(oamAddr);
            wr_dat_q.push_back(oamWdata);
         end
         if (srcReq && srcAck) req_q.push_back(srcAddr);
         if (srcReq) req_seen++;
         if (done) done_cnt++;
         if (err) err_cnt++;
      end
   end

   task automatic clear_logs();
      @(posedge clk);
      #1;
      wr_idx_q.delete();
      wr_dat_q.delete();
      req_q.delete();
      done_cnt = 0;
      err_cnt  = 0;
      req_seen = 0;
   endtask

   task automatic do_start(input logic [15:0] b, input logic [6:0] l);
      @(negedge clk);
      start = 1'b1; srcBase = b; len = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_writes(input int n, input int budget, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (wr_idx_q.size() >= n) begin ok = 1'b1; break; end
      end
      check({name, " wait writes"}, 64'(ok), 64'd1);
   endtask

   task automatic wait_done(input int budget, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (done_cnt >= 1) begin ok = 1'b1; break; end
      end
      check({name, " wait done"}, 64'(ok), 64'd1);
   endtask

   function automatic logic [58:0] outs();
      return {srcReq, srcAddr, oamWe, oamAddr, oamWdata, busy, done, err};
   endfunction

   typedef struct {
      logic        start, vblank, ack;
      logic        sreq;
      logic [15:0] saddr;
      logic        we;
      logic [5:0]  oaddr;
      logic [31:0] wdata;
      logic        busy, done, err;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic sreq, input logic [15:0] sa,
                               input logic we, input logic [5:0] oa, input logic [31:0] wd,
                               input logic bz, input logic dn);
      vec_t v;
      v.start = st; v.vblank = 1'b1; v.ack = 1'b1;
      v.sreq = sreq; v.saddr = sa; v.we = we; v.oaddr = oa; v.wdata = wd;
      v.busy = bz; v.done = dn; v.err = 1'b0;
      return v;
   endfunction

   vec_t tbl[15];

   initial begin
      // srcData in row r is CAFE0000+r, so a REQ in row r captures that word.
      tbl[0]  = mk(1, 0, 16'h0000, 0, 0, 32'h0,          0, 0);
      tbl[1]  = mk(0, 0, 16'h0000, 0, 0, 32'h0,          1, 0);
      tbl[2]  = mk(0, 1, 16'h1000, 0, 0, 32'h0,          1, 0);
      tbl[3]  = mk(0, 0, 16'h0000, 1, 0, 32'hCAFE_0002,  1, 0);
      tbl[4]  = mk(0, 0, 16'h0000, 0, 0, 32'h0,          1, 0);
      tbl[5]  = mk(0, 1, 16'h1004, 0, 0, 32'h0,          1, 0);
      tbl[6]  = mk(0, 0, 16'h0000, 1, 1, 32'hCAFE_0005,  1, 0);
      tbl[7]  = mk(0, 0, 16'h0000, 0, 0, 32'h0,          1, 0);
      tbl[8]  = mk(0, 1, 16'h1008, 0, 0, 32'h0,          1, 0);
      tbl[9]  = mk(0, 0, 16'h0000, 1, 2, 32'hCAFE_0008,  1, 0);
      tbl[10] = mk(0, 0, 16'h0000, 0, 0, 32'h0,          1, 0);
      tbl[11] = mk(0, 1, 16'h100C, 0, 0, 32'h0,          1, 0);
      tbl[12] = mk(0, 0, 16'h0000, 1, 3, 32'hCAFE_000B,  1, 0);
      tbl[13] = mk(0, 0, 16'h0000, 0, 0, 32'h0,          1, 1);
      tbl[14] = mk(0, 0, 16'h0000, 0, 0, 32'h0,          0, 0);

      // Reset state, with start asserted to show err stays low.
      start = 1'b1; vblank = 1'b1; srcAck = 1'b1;
      repeat (3) @(negedge clk);
      #1 check("reset outputs", 64'(outs()), 64'd0);
      start = 1'b0;
      @(negedge clk) rstn = 1'b1;

      // Basic copy, one row per cycle: done 13 cycles after start.
      srcBase = 16'h1000; len = 7'd4;
      for (int r = 0; r < 15; r++) begin
         start = tbl[r].start; vblank = tbl[r].vblank; srcAck = tbl[r].ack;
         tab_data = 32'hCAFE_0000 + 32'(r);
         #1;
         check($sformatf("row %0d", r), 64'(outs()),
               64'({tbl[r].sreq, tbl[r].saddr, tbl[r].we, tbl[r].oaddr, tbl[r].wdata,
                    tbl[r].busy, tbl[r].done, tbl[r].err}));
         @(negedge clk);
      end
      start = 1'b0; srcAck = 1'b1; auto_data = 1'b1; vblank = 1'b1;

      // len=0 copies the whole RAM.
      clear_logs();
      do_start(16'h4000, 7'd0);
      wait_done(400, "full");
      repeat (5) @(negedge clk);
      check("full writes", 64'(wr_idx_q.size()), 64'd64);
      check("full last idx", 64'(wr_idx_q[wr_idx_q.size()-1]), 64'd63);
      check("full done count", 64'(done_cnt), 64'd1);
      begin
         int bad = 0;
         for (int i = 0; i < wr_idx_q.size(); i++)
            if (wr_idx_q[i] != 6'(i) || wr_dat_q[i] != {16'hD00D, 16'h4000 + 16'(4*i)}) bad++;
         check("full order/data", 64'(bad), 64'd0);
      end

      // vblank drop after the second write pauses the copy.
      clear_logs();
      do_start(16'h2000, 7'd4);
      wait_writes(2, 40, "pause");
      @(negedge clk) vblank = 1'b0;
      repeat (50) @(negedge clk);
      check("pause no writes", 64'(wr_idx_q.size()), 64'd2);
      check("pause busy", 64'(busy), 64'd1);
      vblank = 1'b1;
      wait_done(40, "pause");
      check("pause total", 64'(wr_idx_q.size()), 64'd4);
      check("pause resume idx", 64'({wr_idx_q[2], wr_idx_q[3]}), 64'({6'd2, 6'd3}));

      // Source address wraps at the top of the address space.
      clear_logs();
      do_start(16'hFFFC, 7'd2);
      wait_done(40, "wrap");
      check("wrap addrs", 64'({req_q[0], req_q[1]}), 64'({16'hFFFC, 16'h0000}));

      // start while busy: err pulse, transfer untouched.
      clear_logs();
      do_start(16'h3000, 7'd3);
      wait_writes(1, 40, "busy");
      @(negedge clk);
      start = 1'b1; srcBase = 16'h5555; len = 7'd7;
      #1 check("err pulse", 64'(err), 64'd1);
      @(negedge clk) start = 1'b0;
      wait_done(40, "busy");
      check("busy writes", 64'(wr_idx_q.size()), 64'd3);
      check("busy addrs", 64'({req_q[0], req_q[1], req_q[2]}), 64'({16'h3000, 16'h3004, 16'h3008}));

      // start coinciding with done is rejected.
      clear_logs();
      do_start(16'h3100, 7'd1);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
         end
         check("fin reached", 64'(seen), 64'd1);
      end
      start = 1'b1;
      #1 check("err at done", 64'(err), 64'd1);
      @(posedge clk);
      #1 check("idle after done+start", 64'(busy), 64'd0);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("still idle", 64'(busy), 64'd0);

      // Reset mid-transfer abandons it.
      clear_logs();
      do_start(16'h6000, 7'd4);
      wait_writes(1, 40, "rst");
      @(negedge clk) rstn = 1'b0;
      #1 check("mid reset outputs", 64'(outs()), 64'd0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (30) @(negedge clk);
      check("mid reset writes", 64'(wr_idx_q.size()), 64'd1);
      check("mid reset no done", 64'(done_cnt), 64'd0);

`ifdef SPRITE_OAM_DMA_CLEAR_EN
      clear_logs();
      clearMode = 1'b1;
      do_start(16'h7000, 7'd3);
      clearMode = 1'b0;
      wait_done(40, "clear");
      check("clear no srcReq", 64'(req_seen), 64'd0);
      check("clear writes", 64'(wr_idx_q.size()), 64'd3);
      check("clear data", 64'({wr_dat_q[0], wr_dat_q[2]}), 64'({SPRITE_HIDE_WORD, SPRITE_HIDE_WORD}));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
